// File: rtl/decode_stage_if.sv
// Fetch, writeback, register-file read and execute-side signals of the RV32I decode stage.
// The master side drives the instruction and writeback. The slave side is the decoder.
interface decode_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [4:0]  readReg1;
  logic [4:0]  readReg2;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_imm;
  logic [4:0]  out_rd;
  logic        out_we;
  logic [2:0]  out_funct3;
  logic        out_f7b5;
  logic [3:0]  out_class;
  logic        out_illegal;

  modport master (
    output in_valid, instr, pc, wb_valid, wb_rd, out_ready,
    input  in_ready, readReg1, readReg2, out_valid, out_pc, out_imm, out_rd,
           out_we, out_funct3, out_f7b5, out_class, out_illegal
  );

  modport slave (
    input  in_valid, instr, pc, wb_valid, wb_rd, out_ready,
    output in_ready, readReg1, readReg2, out_valid, out_pc, out_imm, out_rd,
           out_we, out_funct3, out_f7b5, out_class, out_illegal
  );
endinterface

// File: rtl/decode_stage.sv
// RV32I decode stage. It holds one decoded instruction for execute and stalls on a register scoreboard.
// Register-file read addresses follow the instruction that is accepted, so operand data lines up with out_valid.
module decode_stage (
  input  logic          clk,
  input  logic          rst,
  decode_stage_if.slave bus
);

  typedef enum logic [3:0] {
    CLS_R      = 4'd0,
    CLS_I      = 4'd1,
    CLS_LOAD   = 4'd2,
    CLS_STORE  = 4'd3,
    CLS_BRANCH = 4'd4,
    CLS_LUI    = 4'd5,
    CLS_AUIPC  = 4'd6,
    CLS_JAL    = 4'd7,
    CLS_JALR   = 4'd8
  } cls_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        we;
    logic [2:0]  funct3;
    logic        f7b5;
    cls_e        cls;
    logic        illegal;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
  } held_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  logic [31:0] ins;
  logic [4:0]  rs1, rs2, rd;
  cls_e        cls;
  logic        illegal, use_rs1, use_rs2, use_rd, we_new, hazard, accept;
  logic [31:0] imm;
  logic [31:0] pending_q, pending_d;
  logic        out_valid_q, out_valid_d;
  held_t       held_q, held_d;

  assign ins = bus.instr;
  assign rs1 = ins[19:15];
  assign rs2 = ins[24:20];
  assign rd  = ins[11:7];

  always_comb begin
    // NOTE: every output of this block gets a value before the case, so no path infers a latch.
    cls     = CLS_R;
    illegal = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    use_rd  = 1'b0;
    imm     = '0;
    case (ins[6:0])
      OP_R:      begin cls = CLS_R;      use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1; end
      OP_IMM:    begin cls = CLS_I;      use_rs1 = 1'b1; use_rd = 1'b1;
                       imm = {{20{ins[31]}}, ins[31:20]}; end
      OP_LOAD:   begin cls = CLS_LOAD;   use_rs1 = 1'b1; use_rd = 1'b1;
                       imm = {{20{ins[31]}}, ins[31:20]}; end
      OP_STORE:  begin cls = CLS_STORE;  use_rs1 = 1'b1; use_rs2 = 1'b1;
                       imm = {{20{ins[31]}}, ins[31:25], ins[11:7]}; end
      OP_BRANCH: begin cls = CLS_BRANCH; use_rs1 = 1'b1; use_rs2 = 1'b1;
                       imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}; end
      OP_LUI:    begin cls = CLS_LUI;    use_rd = 1'b1; imm = {ins[31:12], 12'b0}; end
      OP_AUIPC:  begin cls = CLS_AUIPC;  use_rd = 1'b1; imm = {ins[31:12], 12'b0}; end
      OP_JAL:    begin cls = CLS_JAL;    use_rd = 1'b1;
                       imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}; end
      OP_JALR:   begin cls = CLS_JALR;   use_rs1 = 1'b1; use_rd = 1'b1;
                       imm = {{20{ins[31]}}, ins[31:20]}; end
      default:   illegal = 1'b1;
    endcase
  end

  // The registered scoreboard is read here, so a writeback frees the stall one cycle later.
  assign hazard = (use_rs1 && rs1 != 5'd0 && pending_q[rs1]) ||
                  (use_rs2 && rs2 != 5'd0 && pending_q[rs2]) ||
                  (use_rd  && rd  != 5'd0 && pending_q[rd]);

  assign bus.in_ready = !rst && (!out_valid_q || bus.out_ready) && !hazard;
  assign accept       = bus.in_valid && bus.in_ready;
  assign we_new       = use_rd && (rd != 5'd0);

  always_comb begin
    pending_d = pending_q;
    if (bus.wb_valid) pending_d[bus.wb_rd] = 1'b0;
    if (accept && we_new) pending_d[rd] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_comb begin
    held_d      = held_q;
    out_valid_d = out_valid_q;
    if (accept) begin
      out_valid_d    = 1'b1;
      held_d.pc      = bus.pc;
      held_d.imm     = imm;
      held_d.rd      = rd;
      held_d.we      = we_new;
      held_d.funct3  = ins[14:12];
      held_d.f7b5    = ins[30];
      held_d.cls     = cls;
      held_d.illegal = illegal;
      held_d.rs1     = rs1;
      held_d.rs2     = rs2;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // NOTE: the reset is synchronous, so it sits inside the clocked block and is not in the sensitivity list.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      held_q      <= '0;
      pending_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      held_q      <= held_d;
      pending_q   <= pending_d;
    end
  end

  assign bus.readReg1    = accept ? rs1 : held_q.rs1;
  assign bus.readReg2    = accept ? rs2 : held_q.rs2;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_pc      = held_q.pc;
  assign bus.out_imm     = held_q.imm;
  assign bus.out_rd      = held_q.rd;
  assign bus.out_we      = held_q.we;
  assign bus.out_funct3  = held_q.funct3;
  assign bus.out_f7b5    = held_q.f7b5;
  assign bus.out_class   = held_q.cls;
  assign bus.out_illegal = held_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage. A queue holds the expected decodes, and a monitor checks each one when execute consumes it.
// Stall, hold, scoreboard and reset behaviour are also checked directly in the stimulus sequence.
module tb_decode_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        we;
    logic [2:0]  funct3;
    logic        f7b5;
    logic [3:0]  cls;
    logic        illegal;
  } exp_t;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb_q[$];

  decode_stage_if bus ();

  decode_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] imm, input logic [4:0] rd,
                      input logic we, input logic [2:0] f3, input logic f7, input logic [3:0] cls,
                      input logic ill);
    exp_t e;
    e.pc = pc; e.imm = imm; e.rd = rd; e.we = we;
    e.funct3 = f3; e.f7b5 = f7; e.cls = cls; e.illegal = ill;
    sb_q.push_back(e);
  endtask

  // Inputs change 1 time unit after the rising edge. Outputs are sampled on the falling edge.
  task automatic drive(input logic r, input logic v, input logic [31:0] ins, input logic [31:0] p,
                       input logic ordy, input logic wbv, input logic [4:0] wbr);
    @(posedge clk);
    #1;
    rst           = r;
    bus.in_valid  = v;
    bus.instr     = ins;
    bus.pc        = p;
    bus.out_ready = ordy;
    bus.wb_valid  = wbv;
    bus.wb_rd     = wbr;
  endtask

  // Present an instruction to a free stage. It must be accepted this cycle.
  task automatic issue(input logic [31:0] ins, input logic [31:0] p, input logic [31:0] imm,
                       input logic [4:0] rd, input logic we, input logic [2:0] f3,
                       input logic f7, input logic [3:0] cls);
    drive(1'b0, 1'b1, ins, p, 1'b1, 1'b0, 5'd0);
    @(negedge clk);
    check("stream_in_ready", 32'(bus.in_ready), 32'd1);
    push(p, imm, rd, we, f3, f7, cls, 1'b0);
  endtask

  // Monitor: compare the head of the queue whenever execute consumes the held instruction.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_underflow: got consume with empty queue, required an expected entry at %0t", $time);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_pc",      bus.out_pc,               e.pc);
        check("sb_imm",     bus.out_imm,              e.imm);
        check("sb_rd",      32'(bus.out_rd),          32'(e.rd));
        check("sb_we",      32'(bus.out_we),          32'(e.we));
        check("sb_funct3",  32'(bus.out_funct3),      32'(e.funct3));
        check("sb_f7b5",    32'(bus.out_f7b5),        32'(e.f7b5));
        check("sb_illegal", 32'(bus.out_illegal),     32'(e.illegal));
        if (!e.illegal) check("sb_class", 32'(bus.out_class), 32'(e.cls));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required $finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.instr = '0; bus.pc = '0;
    bus.out_ready = 1'b0; bus.wb_valid = 1'b0; bus.wb_rd = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready",  32'(bus.in_ready),  32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_pending",   dut.pending_q,      32'd0);
    check("rst_out_imm",   bus.out_imm,        32'd0);
    check("rst_readReg1",  32'(bus.readReg1),  32'd0);

    // addi x1,x0,5 accepted in the first cycle with rst low
    drive(1'b0, 1'b1, 32'h0050_0093, 32'h100, 1'b0, 1'b0, 5'd0);
    @(negedge clk);
    check("addi_in_ready", 32'(bus.in_ready), 32'd1);
    push(32'h100, 32'd5, 5'd1, 1'b1, 3'd0, 1'b0, 4'd1, 1'b0);

    // add x3,x1,x2 stalls on x1 while execute is free to consume
    drive(1'b0, 1'b1, 32'h0020_81B3, 32'h104, 1'b1, 1'b0, 5'd0);
    @(negedge clk);
    check("addi_out_valid", 32'(bus.out_valid), 32'd1);
    check("addi_class",     32'(bus.out_class), 32'd1);
    check("addi_imm",       bus.out_imm,        32'd5);
    check("addi_rd",        32'(bus.out_rd),    32'd1);
    check("addi_we",        32'(bus.out_we),    32'd1);
    check("pending_x1",     dut.pending_q,      32'h0000_0002);
    check("add_stall",      32'(bus.in_ready),  32'd0);

    // writeback of x1 at cycle T: still stalled at T
    drive(1'b0, 1'b1, 32'h0020_81B3, 32'h104, 1'b1, 1'b1, 5'd1);
    @(negedge clk);
    check("wb_T_in_ready",  32'(bus.in_ready),  32'd0);
    check("wb_T_out_valid", 32'(bus.out_valid), 32'd0);

    // T+1: stall released
    drive(1'b0, 1'b1, 32'h0020_81B3, 32'h104, 1'b1, 1'b0, 5'd0);
    @(negedge clk);
    check("wb_T1_in_ready", 32'(bus.in_ready), 32'd1);
    check("add_readReg1",   32'(bus.readReg1), 32'd1);
    check("add_readReg2",   32'(bus.readReg2), 32'd2);
    push(32'h104, 32'd0, 5'd3, 1'b1, 3'd0, 1'b0, 4'd0, 1'b0);

    // sw x1,8(x2)
    drive(1'b0, 1'b1, 32'h0011_2423, 32'h108, 1'b1, 1'b0, 5'd0);
    @(negedge clk);
    check("sw_in_ready", 32'(bus.in_ready), 32'd1);
    check("sw_readReg1", 32'(bus.readReg1), 32'd2);
    check("sw_readReg2", 32'(bus.readReg2), 32'd1);
    check("pending_x3",  dut.pending_q,     32'h0000_0008);
    push(32'h108, 32'd8, 5'd8, 1'b0, 3'd2, 1'b0, 4'd3, 1'b0);

    // lui x5,0x12345 replaces sw back-to-back
    drive(1'b0, 1'b1, 32'h1234_52B7, 32'h10C, 1'b1, 1'b0, 5'd0);
    @(negedge clk);
    check("sw_class",    32'(bus.out_class), 32'd3);
    check("sw_imm",      bus.out_imm,        32'd8);
    check("sw_we",       32'(bus.out_we),    32'd0);
    check("sw_pending",  dut.pending_q,      32'h0000_0008);
    check("lui_in_ready", 32'(bus.in_ready), 32'd1);
    push(32'h10C, 32'h1234_5000, 5'd5, 1'b1, 3'd5, 1'b0, 4'd5, 1'b0);

    // execute back-pressure: lui held for three cycles
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 32'hFFFF_FFFF, 32'h110, 1'b0, 1'b0, 5'd0);
      @(negedge clk);
      check("hold_out_valid", 32'(bus.out_valid), 32'd1);
      check("hold_imm",       bus.out_imm,        32'h1234_5000);
      check("hold_rd",        32'(bus.out_rd),    32'd5);
      check("hold_in_ready",  32'(bus.in_ready),  32'd0);
      check("hold_readReg1",  32'(bus.readReg1),  32'd8);
      check("hold_readReg2",  32'(bus.readReg2),  32'd3);
    end

    // consume lui and accept the illegal word in the same cycle
    drive(1'b0, 1'b1, 32'hFFFF_FFFF, 32'h110, 1'b1, 1'b0, 5'd0);
    @(negedge clk);
    check("b2b_in_ready", 32'(bus.in_ready), 32'd1);
    check("pending_x3x5", dut.pending_q,     32'h0000_0028);
    push(32'h110, 32'd0, 5'd31, 1'b0, 3'd7, 1'b1, 4'd0, 1'b1);

    // addi x6,x0,7 accepted while the illegal instruction leaves
    drive(1'b0, 1'b1, 32'h0070_0313, 32'h114, 1'b1, 1'b0, 5'd0);
    @(negedge clk);
    check("ill_out_valid", 32'(bus.out_valid),   32'd1);
    check("ill_flag",      32'(bus.out_illegal), 32'd1);
    check("ill_we",        32'(bus.out_we),      32'd0);
    check("ill_imm",       bus.out_imm,          32'd0);
    check("ill_pending",   dut.pending_q,        32'h0000_0028);
    check("x6_in_ready",   32'(bus.in_ready),    32'd1);
    push(32'h114, 32'd7, 5'd6, 1'b1, 3'd0, 1'b0, 4'd1, 1'b0);

    // reset while an instruction is held and x3 is pending
    drive(1'b1, 1'b0, 32'h0000_0013, 32'h118, 1'b0, 1'b0, 5'd0);
    @(negedge clk);
    check("prerst_out_valid", 32'(bus.out_valid), 32'd1);
    check("prerst_pending",   dut.pending_q,      32'h0000_0068);
    check("inrst_in_ready",   32'(bus.in_ready),  32'd0);
    sb_q.delete();

    // lw x7,4(x0) is accepted in the first cycle after reset, then a back-to-back stream follows
    drive(1'b0, 1'b1, 32'h0040_2383, 32'h200, 1'b1, 1'b0, 5'd0);
    @(negedge clk);
    check("postrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("postrst_pending",   dut.pending_q,      32'd0);
    check("postrst_imm",       bus.out_imm,        32'd0);
    check("postrst_in_ready",  32'(bus.in_ready),  32'd1);
    push(32'h200, 32'd4, 5'd7, 1'b1, 3'd2, 1'b0, 4'd2, 1'b0);

    issue(32'hFF9F_F06F, 32'h204, 32'hFFFF_FFF8, 5'd0,  1'b0, 3'd7, 1'b1, 4'd7); // jal x0,-8
    issue(32'hFE00_08E3, 32'h208, 32'hFFFF_FFF0, 5'd17, 1'b0, 3'd0, 1'b1, 4'd4); // beq x0,x0,-16
    issue(32'hFFFF_F417, 32'h20C, 32'hFFFF_F000, 5'd8,  1'b1, 3'd7, 1'b1, 4'd6); // auipc x8,0xfffff
    issue(32'hFFF0_04E7, 32'h210, 32'hFFFF_FFFF, 5'd9,  1'b1, 3'd0, 1'b1, 4'd8); // jalr x9,-1(x0)
    issue(32'h0000_0013, 32'h214, 32'd0,         5'd0,  1'b0, 3'd0, 1'b0, 4'd1); // nop
    issue(32'h40C5_8533, 32'h218, 32'd0,         5'd10, 1'b1, 3'd0, 1'b1, 4'd0); // sub x10,x11,x12

    // drain the stage with a writeback of x7
    drive(1'b0, 1'b0, 32'h0000_0000, 32'h0, 1'b1, 1'b1, 5'd7);
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h0000_0000, 32'h0, 1'b1, 1'b0, 5'd0);
    @(negedge clk);
    check("drain_out_valid", 32'(bus.out_valid), 32'd0);
    check("drain_pending",   dut.pending_q,      32'h0000_0700);
    check("sb_empty",        32'(sb_q.size()),   32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
